st_feedback_fifo: RTL and testbench
===================================

ST_FEEDBACK_FIFO -- requirements
Module: st_feedback_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of data field of both interface ports.
REQ-002 SHALL have parameter DEPTH, default 8, buffer entries; power of two, >= 2.
REQ-003 SHALL have parameter STORE_FWD, default 0, 0 = cut-through, 1 = store-and-forward.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port i_feedback_if  avl_st_mini_if.dst  -  sink: valid, startofpacket, endofpacket, data[DATA_WIDTH] in; ready out.
REQ-007 SHALL have port o_feedback_if  avl_st_mini_if.src  -  source: valid, startofpacket, endofpacket, data[DATA_WIDTH] out; ready in.
REQ-008 SHALL have port clr_stats  input  1  synchronous clear of pkt_count and frame_err.
REQ-009 SHALL have port fill_level  output  $clog2(DEPTH)+1  words currently buffered.
REQ-010 SHALL have port pkt_count  output  16  count of EOP words accepted at output.
REQ-011 SHALL have port frame_err  output  1  sticky input framing-error flag.

Function
REQ-012 Input beat accepted iff i.valid && i.ready at clk edge; output beat iff o.valid && o.ready.
REQ-013 i.ready SHALL equal (fill_level != DEPTH), independent of i.valid and o.ready.
REQ-014 Each buffer entry SHALL store {startofpacket, endofpacket, data} unmodified; output order equals input order.
REQ-015 Latency SHALL be 1 cycle: a word accepted at edge N into an empty buffer SHALL present o.valid at edge N (visible in cycle N+1); no combinational input-to-output path.
REQ-016 fill_level SHALL increment on push only, decrement on pop only, hold on simultaneous push and pop.
REQ-017 Simultaneous push and pop at fill_level = DEPTH-1 or 1 SHALL be legal; when full, i.ready = 0 and no push occurs even if a pop occurs that cycle.
REQ-018 Read/write pointers SHALL wrap modulo DEPTH.
REQ-019 STORE_FWD = 0: o.valid SHALL equal (fill_level != 0).
REQ-020 STORE_FWD = 1: o.valid SHALL equal (fill_level != 0) && (eop_cnt != 0 || fill_level == DEPTH), where eop_cnt = buffered words with endofpacket set; full-buffer release prevents deadlock on packets longer than DEPTH.
REQ-021 eop_cnt SHALL update on both push and pop in the same cycle without loss.
REQ-022 Once o.valid is asserted, it and the output fields SHALL stay stable until the beat is accepted.
REQ-023 Input framing tracker SHALL be a 2-state FSM: IDLE -> IN_PKT on accepted SOP without EOP; IN_PKT -> IDLE on accepted EOP; single-beat packet (SOP and EOP) stays IDLE.
REQ-024 frame_err SHALL set on accepted SOP in IN_PKT, or accepted non-SOP beat in IDLE; offending beat still buffered and forwarded; FSM then follows the beat's EOP.
REQ-025 pkt_count SHALL increment on each output beat with endofpacket, wrapping at 2^16.
REQ-026 clr_stats SHALL clear pkt_count and frame_err next edge; a simultaneous increment/set event is discarded (clear wins).

Reset
REQ-027 On reset_n low, immediately: buffer empty, fill_level = 0, eop_cnt = 0, o.valid = 0, i.ready = 1 after release, pkt_count = 0, frame_err = 0, FSM = IDLE.
REQ-028 Reset mid-packet SHALL discard all buffered words; buffer contents need not clear.
REQ-029 Outputs SHALL reach reset values asynchronously; release synchronised externally.

Structure
REQ-030 Package avl_st_pkg SHALL hold the stored-word struct typedef (sop, eop, data) and framing-FSM state enum.
REQ-031 Storage and pointers SHALL be sub-module st_fifo_core (DEPTH, width); framing FSM, eop_cnt, release logic and statistics in st_feedback_fifo.

Verification
REQ-032 DEPTH=8, STORE_FWD=0, o.ready=1, one 4-beat packet 0x1..0x4 -> output identical, first o.valid one cycle after first accept, pkt_count=1.
REQ-033 DEPTH=8, o.ready=0, 10 beats offered -> i.ready low after 8 accepts, fill_level=8; o.ready=1 -> all 10 out in order, no loss.
REQ-034 STORE_FWD=1, 3-beat packet with 2-cycle gaps -> o.valid low until EOP beat buffered, then 3 back-to-back beats.
REQ-035 STORE_FWD=1, DEPTH=4, 6-beat packet -> release at fill_level=4, all 6 beats delivered.
REQ-036 SOP, SOP, EOP input sequence -> frame_err=1 after second SOP, all 3 beats forwarded; clr_stats pulse -> frame_err=0, pkt_count=0.
REQ-037 reset_n low with fill_level=5 -> o.valid=0, fill_level=0 immediately; new packet after release passes cleanly.

Source files
------------

// File: rtl/avl_st_pkg.sv
// Shared types for the mini Avalon-ST feedback FIFO: framing tracker states and per-beat delimiter flags.
package avl_st_pkg;

    typedef enum logic {
        FR_IDLE   = 1'b0,
        FR_IN_PKT = 1'b1
    } frame_state_t;

    // Packet delimiters stored with every word. A package cannot carry the per-instance
    // DATA_WIDTH, so the full stored word is these flags followed by the data field.
    typedef struct packed {
        logic sop;
        logic eop;
    } st_flags_t;

endpackage

// File: rtl/avl_st_mini_if.sv
// Minimal streaming handshake bundle: one data beat with packet delimiters, valid/ready flow control.
interface avl_st_mini_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  valid;
    logic                  ready;
    logic                  startofpacket;
    logic                  endofpacket;
    logic [DATA_WIDTH-1:0] data;

    modport src (output valid, startofpacket, endofpacket, data, input ready);
    modport dst (input valid, startofpacket, endofpacket, data, output ready);
endinterface

// File: rtl/st_fifo_core.sv
// Circular word buffer of DEPTH entries; the head entry is readable the cycle after it is written.
module st_fifo_core #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_fill
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_fill;

    // Storage is not reset: emptiness is defined purely by the pointers and fill count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_fill  = r_fill;

endmodule

// File: rtl/st_feedback_fifo.sv
// Packet-aware streaming FIFO: cut-through or store-and-forward release, input framing check, output packet count.
module st_feedback_fifo
    import avl_st_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int STORE_FWD  = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    avl_st_mini_if.dst             i_feedback_if,
    avl_st_mini_if.src             o_feedback_if,
    input  logic                   clr_stats,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [15:0]            pkt_count,
    output logic                   frame_err
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        st_flags_t             flags;
        logic [DATA_WIDTH-1:0] data;
    } st_word_t;

    st_word_t     w_in_word;
    st_word_t     w_out_word;
    logic [CW-1:0] w_fill;
    logic         w_full;
    logic         w_push;
    logic         w_pop;
    logic         w_valid;
    logic         w_frame_evt;
    frame_state_t r_state;
    frame_state_t w_state_next;
    logic [CW-1:0] r_eop_cnt;
    logic [15:0]  r_pkt_count;
    logic         r_frame_err;

    assign w_in_word = {i_feedback_if.startofpacket, i_feedback_if.endofpacket, i_feedback_if.data};
    assign w_full    = (w_fill == CW'(DEPTH));
    assign w_push    = i_feedback_if.valid && !w_full;
    assign w_pop     = w_valid && o_feedback_if.ready;

    st_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(st_word_t))
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata (w_in_word),
        .i_pop   (w_pop),
        .o_rdata (w_out_word),
        .o_fill  (w_fill)
    );

    // Store-and-forward holds data until a whole packet is in, unless the buffer is full.
    assign w_valid = (w_fill != '0) && ((STORE_FWD == 0) || (r_eop_cnt != '0) || w_full);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_eop_cnt <= '0;
        end else begin
            case ({w_push && w_in_word.flags.eop, w_pop && w_out_word.flags.eop})
                2'b10:   r_eop_cnt <= r_eop_cnt + 1'b1;
                2'b01:   r_eop_cnt <= r_eop_cnt - 1'b1;
                default: r_eop_cnt <= r_eop_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A malformed beat still resynchronises the tracker on its own EOP.
    always_comb begin
        w_state_next = r_state;
        if (w_push) begin
            w_state_next = w_in_word.flags.eop ? FR_IDLE : FR_IN_PKT;
        end
    end

    always_comb begin
        w_frame_evt = 1'b0;
        if (w_push) begin
            w_frame_evt = (r_state == FR_IDLE) ? !w_in_word.flags.sop : w_in_word.flags.sop;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_count <= '0;
            r_frame_err <= 1'b0;
        end else if (clr_stats) begin
            r_pkt_count <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_pop && w_out_word.flags.eop) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
            if (w_frame_evt) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign i_feedback_if.ready         = !w_full;
    assign o_feedback_if.valid         = w_valid;
    assign o_feedback_if.startofpacket = w_out_word.flags.sop;
    assign o_feedback_if.endofpacket   = w_out_word.flags.eop;
    assign o_feedback_if.data          = w_out_word.data;
    assign fill_level                  = w_fill;
    assign pkt_count                   = r_pkt_count;
    assign frame_err                   = r_frame_err;

endmodule

// File: tb/tb_st_feedback_fifo.sv
// Bench for st_feedback_fifo: a cut-through DEPTH=8 instance and a store-and-forward DEPTH=4 instance.
`timescale 1ns/1ps
module tb_st_feedback_fifo;
    localparam int DW = 32;
    localparam int D0 = 8;
    localparam int D1 = 4;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } wd_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          vld [2];
    logic          sop_i [2];
    logic          eop_i [2];
    logic [DW-1:0] dat [2];
    logic          ordy [2];
    logic          clr [2];

    logic          obs_ready [2];
    logic          obs_valid [2];
    logic          obs_sop [2];
    logic          obs_eop [2];
    logic [DW-1:0] obs_data [2];
    logic [3:0]    obs_fill [2];
    logic [15:0]   obs_pkt [2];
    logic          obs_err [2];

    logic [3:0]  fill0;
    logic [2:0]  fill1;
    logic [15:0] pkt0, pkt1;
    logic        err0, err1;

    avl_st_mini_if #(.DATA_WIDTH(DW)) in0 ();
    avl_st_mini_if #(.DATA_WIDTH(DW)) out0 ();
    avl_st_mini_if #(.DATA_WIDTH(DW)) in1 ();
    avl_st_mini_if #(.DATA_WIDTH(DW)) out1 ();

    assign in0.valid = vld[0];
    assign in0.startofpacket = sop_i[0];
    assign in0.endofpacket = eop_i[0];
    assign in0.data = dat[0];
    assign out0.ready = ordy[0];
    assign in1.valid = vld[1];
    assign in1.startofpacket = sop_i[1];
    assign in1.endofpacket = eop_i[1];
    assign in1.data = dat[1];
    assign out1.ready = ordy[1];

    assign obs_ready[0] = in0.ready;
    assign obs_valid[0] = out0.valid;
    assign obs_sop[0]   = out0.startofpacket;
    assign obs_eop[0]   = out0.endofpacket;
    assign obs_data[0]  = out0.data;
    assign obs_fill[0]  = fill0;
    assign obs_pkt[0]   = pkt0;
    assign obs_err[0]   = err0;
    assign obs_ready[1] = in1.ready;
    assign obs_valid[1] = out1.valid;
    assign obs_sop[1]   = out1.startofpacket;
    assign obs_eop[1]   = out1.endofpacket;
    assign obs_data[1]  = out1.data;
    assign obs_fill[1]  = {1'b0, fill1};
    assign obs_pkt[1]   = pkt1;
    assign obs_err[1]   = err1;

    st_feedback_fifo #(.DATA_WIDTH(DW), .DEPTH(D0), .STORE_FWD(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .i_feedback_if(in0), .o_feedback_if(out0),
        .clr_stats(clr[0]), .fill_level(fill0), .pkt_count(pkt0), .frame_err(err0)
    );

    st_feedback_fifo #(.DATA_WIDTH(DW), .DEPTH(D1), .STORE_FWD(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .i_feedback_if(in1), .o_feedback_if(out1),
        .clr_stats(clr[1]), .fill_level(fill1), .pkt_count(pkt1), .frame_err(err1)
    );

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int dep [2] = '{D0, D1};
    bit sf [2] = '{1'b0, 1'b1};

    // Reference model: buffered words as a queue, plus packet/framing bookkeeping.
    wd_t         mq [2][$];
    logic [15:0] m_pkt [2];
    logic        m_err [2];
    bit          m_inpkt [2];
    wd_t         out_log [2][$];
    int          pop_edge [2][$];
    int          pop_fill [2][$];
    int          push_edge [2][$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    function automatic bit m_valid(int d);
        int ne = 0;
        if (mq[d].size() == 0) return 1'b0;
        if (!sf[d]) return 1'b1;
        for (int k = 0; k < mq[d].size(); k++) if (mq[d][k].eop) ne++;
        return (ne != 0) || (mq[d].size() == dep[d]);
    endfunction

    always @(negedge clk) begin : cmp
        bit  pv, push, pop, pkt_ev, err_ev;
        wd_t head;
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                mq[d].delete();
                m_pkt[d] = '0;
                m_err[d] = 1'b0;
                m_inpkt[d] = 1'b0;
                chk("rst_valid", d, obs_valid[d], 0);
                chk("rst_fill", d, obs_fill[d], 0);
                chk("rst_pkt", d, obs_pkt[d], 0);
                chk("rst_err", d, obs_err[d], 0);
            end else begin
                pv = m_valid(d);
                chk("ready", d, obs_ready[d], mq[d].size() != dep[d]);
                chk("valid", d, obs_valid[d], pv);
                chk("fill", d, obs_fill[d], mq[d].size());
                chk("pkt_count", d, obs_pkt[d], m_pkt[d]);
                chk("frame_err", d, obs_err[d], m_err[d]);
                if (pv) begin
                    head = mq[d][0];
                    chk("out_word", d, {obs_sop[d], obs_eop[d], obs_data[d]}, head);
                end
                push = vld[d] && (mq[d].size() != dep[d]);
                pop = pv && ordy[d];
                pkt_ev = 1'b0;
                err_ev = 1'b0;
                if (pop) begin
                    head = mq[d].pop_front();
                    out_log[d].push_back({obs_sop[d], obs_eop[d], obs_data[d]});
                    pop_edge[d].push_back(cyc + 1);
                    pop_fill[d].push_back(int'(obs_fill[d]));
                    pkt_ev = head.eop;
                end
                if (push) begin
                    err_ev = m_inpkt[d] ? sop_i[d] : !sop_i[d];
                    m_inpkt[d] = !eop_i[d];
                    mq[d].push_back({sop_i[d], eop_i[d], dat[d]});
                    push_edge[d].push_back(cyc + 1);
                end
                if (clr[d]) begin
                    m_pkt[d] = '0;
                    m_err[d] = 1'b0;
                end else begin
                    if (pkt_ev) m_pkt[d] = m_pkt[d] + 16'd1;
                    if (err_ev) m_err[d] = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_logs(input int d);
        out_log[d].delete();
        pop_edge[d].delete();
        pop_fill[d].delete();
        push_edge[d].delete();
    endtask

    task automatic send(input int d, input logic s, input logic e, input logic [DW-1:0] v);
        bit acc = 1'b0;
        vld[d] = 1'b1;
        sop_i[d] = s;
        eop_i[d] = e;
        dat[d] = v;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = obs_ready[d];
            @(posedge clk);
            #1;
        end
        vld[d] = 1'b0;
        chk("send_accept", d, acc, 1);
        $display("tx dut%0d sop=%0b eop=%0b data=%08h", d, s, e, v);
    endtask

    task automatic feed(input int d, input int n, input logic [DW-1:0] base, input int gap);
        for (int i = 0; i < n; i++) begin
            send(d, i == 0, i == n - 1, base + DW'(i));
            if (i != n - 1) tick(gap);
        end
    endtask

    task automatic drain(input int d, input int n);
        for (int t = 0; t < 400 && out_log[d].size() < n; t++) tick(1);
        chk("drain_count", d, out_log[d].size(), n);
    endtask

    task automatic chk_word(input string nm, input int d, input int idx, input logic s, input logic e, input logic [DW-1:0] v);
        if (idx < out_log[d].size()) chk(nm, d, out_log[d][idx], {s, e, v});
        else chk({nm, "_missing"}, d, out_log[d].size(), idx + 1);
    endtask

    initial begin : wdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        wd_t exp_q [$];
        for (int d = 0; d < 2; d++) begin
            vld[d] = 1'b0; sop_i[d] = 1'b0; eop_i[d] = 1'b0;
            dat[d] = '0; ordy[d] = 1'b0; clr[d] = 1'b0;
        end
        tick(3);
        chk("reset_ready", 0, obs_ready[0], 1);
        chk("reset_valid", 0, obs_valid[0], 0);
        chk("reset_fill", 1, obs_fill[1], 0);
        reset_n = 1'b1;
        tick(2);
        chk("post_reset_ready", 0, obs_ready[0], 1);

        // 4-beat packet through the cut-through instance
        ordy[0] = 1'b1;
        clr_logs(0);
        feed(0, 4, 32'h1, 0);
        drain(0, 4);
        for (int i = 0; i < 4; i++) chk_word("pkt4_word", 0, i, i == 0, i == 3, DW'(i + 1));
        chk("first_out_latency", 0, pop_edge[0][0], push_edge[0][0] + 1);
        chk("pkt4_count", 0, obs_pkt[0], 1);

        // 10 beats against a stalled output
        ordy[0] = 1'b0;
        clr_logs(0);
        fork
            feed(0, 10, 32'h100, 0);
            begin
                tick(14);
                chk("stall_fill", 0, obs_fill[0], 8);
                chk("stall_ready", 0, obs_ready[0], 0);
                chk("stall_accepts", 0, push_edge[0].size(), 8);
                ordy[0] = 1'b1;
            end
        join
        drain(0, 10);
        for (int i = 0; i < 10; i++) chk_word("stall_word", 0, i, i == 0, i == 9, 32'h100 + DW'(i));
        chk("stall_pkt_count", 0, obs_pkt[0], 2);

        // SOP, SOP, EOP framing error, then statistics clear
        clr_logs(0);
        send(0, 1'b1, 1'b0, 32'hA0);
        chk("ferr_first_sop", 0, obs_err[0], 0);
        send(0, 1'b1, 1'b0, 32'hB0);
        chk("ferr_second_sop", 0, obs_err[0], 1);
        send(0, 1'b0, 1'b1, 32'hC0);
        drain(0, 3);
        chk_word("ferr_word0", 0, 0, 1'b1, 1'b0, 32'hA0);
        chk_word("ferr_word1", 0, 1, 1'b1, 1'b0, 32'hB0);
        chk_word("ferr_word2", 0, 2, 1'b0, 1'b1, 32'hC0);
        chk("ferr_pkt_count", 0, obs_pkt[0], 3);
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        chk("clr_err", 0, obs_err[0], 0);
        chk("clr_pkt", 0, obs_pkt[0], 0);

        // Store-and-forward: 3-beat packet with 2-cycle gaps
        ordy[1] = 1'b1;
        clr_logs(1);
        send(1, 1'b1, 1'b0, 32'h200);
        tick(2);
        chk("sf_hold_valid1", 1, obs_valid[1], 0);
        chk("sf_hold_fill1", 1, obs_fill[1], 1);
        send(1, 1'b0, 1'b0, 32'h201);
        tick(2);
        chk("sf_hold_valid2", 1, obs_valid[1], 0);
        chk("sf_hold_fill2", 1, obs_fill[1], 2);
        send(1, 1'b0, 1'b1, 32'h202);
        drain(1, 3);
        for (int i = 0; i < 3; i++) begin
            chk_word("sf_word", 1, i, i == 0, i == 2, 32'h200 + DW'(i));
            chk("sf_burst_edge", 1, pop_edge[1][i], push_edge[1][2] + 1 + i);
        end

        // Store-and-forward: 6-beat packet longer than the buffer
        clr_logs(1);
        feed(1, 6, 32'h300, 0);
        drain(1, 6);
        chk("sf_full_release_fill", 1, pop_fill[1][0], 4);
        chk("sf_full_release_edge", 1, pop_edge[1][0], push_edge[1][3] + 1);
        for (int i = 0; i < 6; i++) chk_word("sf_long_word", 1, i, i == 0, i == 5, 32'h300 + DW'(i));
        chk("sf_pkt_count", 1, obs_pkt[1], 2);

        // Non-SOP beat while idle, then clear colliding with another error
        clr_logs(1);
        send(1, 1'b0, 1'b1, 32'h400);
        chk("idle_nonsop_err", 1, obs_err[1], 1);
        clr[1] = 1'b1;
        send(1, 1'b0, 1'b1, 32'h401);
        clr[1] = 1'b0;
        chk("clear_wins_err", 1, obs_err[1], 0);
        drain(1, 2);
        chk_word("nonsop_word", 1, 1, 1'b0, 1'b1, 32'h401);

        // Three packets under a randomly toggling output ready
        clr_logs(0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back({i == 0, i == 2, 32'h500 + DW'(i)});
        exp_q.push_back({1'b1, 1'b1, 32'h510});
        for (int i = 0; i < 5; i++) exp_q.push_back({i == 0, i == 4, 32'h520 + DW'(i)});
        fork
            begin
                feed(0, 3, 32'h500, 0);
                feed(0, 1, 32'h510, 0);
                feed(0, 5, 32'h520, 1);
            end
            begin
                repeat (60) begin
                    ordy[0] = 1'($urandom_range(0, 1));
                    tick(1);
                end
                ordy[0] = 1'b1;
            end
        join
        drain(0, 9);
        for (int i = 0; i < 9; i++) chk_word("rand_word", 0, i, exp_q[i].sop, exp_q[i].eop, exp_q[i].data);
        chk("rand_pkt_count", 0, obs_pkt[0], 3);

        // Asynchronous reset with 5 words buffered
        ordy[0] = 1'b0;
        clr_logs(0);
        for (int i = 0; i < 5; i++) send(0, i == 0, 1'b0, 32'h600 + DW'(i));
        chk("pre_reset_fill", 0, obs_fill[0], 5);
        chk("pre_reset_valid", 0, obs_valid[0], 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 0, obs_valid[0], 0);
        chk("async_rst_fill", 0, obs_fill[0], 0);
        chk("async_rst_ready", 0, obs_ready[0], 1);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        ordy[0] = 1'b1;
        clr_logs(0);
        feed(0, 2, 32'h700, 0);
        drain(0, 2);
        chk_word("after_rst_word0", 0, 0, 1'b1, 1'b0, 32'h700);
        chk_word("after_rst_word1", 0, 1, 1'b0, 1'b1, 32'h701);
        chk("after_rst_pkt", 0, obs_pkt[0], 1);
        chk("after_rst_err", 0, obs_err[0], 0);

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
